int2flt_arbiter: RTL

//  Shares one int-to-float converter (8b sign-magnitude int -> 13b float: sign, 4b exp, 8b mantissa)

---
 rtl/int2flt_arbiter_pkg.sv | 20 ++
 rtl/int2flt_core.sv | 40 ++++
 rtl/int2flt_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/int2flt_arbiter_pkg.sv
// Shared widths and float field layout for the int-to-float arbiter slice.
// Float word is {sign, exponent, mantissa} with the leading mantissa one explicit.
package int2flt_arbiter_pkg;

   localparam int INT_W = 8;
   localparam int FLT_W = 13;
   localparam int EXP_W = 4;
   localparam int MAN_W = 8;

   localparam int FLT_SIGN_BIT = 12;
   localparam int FLT_EXP_LSB  = 8;
   localparam int FLT_MAN_LSB  = 0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } flt_t;

endpackage

// File: rtl/int2flt_core.sv
// Sign-magnitude int8 to 13b float converter; purely combinational, no flow control.
// Exponent is 1 + leading-one index, so magnitude 0 is the only value with exponent 0.
import int2flt_arbiter_pkg::*;

module int2flt_core (
   input  logic [INT_W-1:0] op,
   output flt_t             res
);

   logic [INT_W-2:0] mag;
   logic [2:0]       lead;
   logic             found;
   logic [2:0]       sh;

   assign mag = op[INT_W-2:0];

   // Ascending scan: the highest set bit is the last one written.
   always_comb begin
      lead  = '0;
      found = 1'b0;
      for (int i = 0; i < INT_W - 1; i++) begin
         if (mag[i]) begin
            lead  = 3'(i);
            found = 1'b1;
         end
      end
   end

   assign sh = 3'd7 - lead;

   always_comb begin
      res      = '0;
      res.sign = op[INT_W-1];
      if (found) begin
         res.exp = {1'b0, lead} + 4'd1;
         res.man = {1'b0, mag} << sh;
      end
   end

endmodule

// File: rtl/int2flt_arbiter.sv
// Round-robin share of one int2flt converter among N requesters; 1-cycle latency into a single result slot.
// Backpressure: a held, unconsumed result blocks all grants and freezes the rr pointer.
import int2flt_arbiter_pkg::*;

module int2flt_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2,
   parameter int CW  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req_valid,
   input  logic [INT_W*N-1:0] req_data,
   output logic [N-1:0]       req_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FLT_W-1:0]   out_flt,
   output logic [IDW-1:0]     out_id,
   output logic [CW-1:0]      conv_count
);

   logic             free;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   grant_idx;
   logic             grant_found;
   logic [INT_W-1:0] operand;
   flt_t             conv;

   logic             valid_q;
   flt_t             flt_q;
   logic [IDW-1:0]   id_q;
   logic [CW-1:0]    cnt_q;

   assign free = !valid_q || out_ready;

   // Search starts one past the last winner so the previous winner has lowest priority.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (free) begin
         for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(ptr) + k) % N);
            if (!grant_found && req_valid[cand]) begin
               grant_found = 1'b1;
               grant_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_found) req_ready[grant_idx] = 1'b1;
   end

   assign operand = req_data[int'(grant_idx)*INT_W +: INT_W];

   int2flt_core u_core (
      .op  (operand),
      .res (conv)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         flt_q   <= '0;
         id_q    <= '0;
         ptr     <= IDW'(N - 1);
         cnt_q   <= '0;
      end else begin
         if (grant_found) begin
            flt_q   <= conv;
            id_q    <= grant_idx;
            valid_q <= 1'b1;
            ptr     <= grant_idx;
            cnt_q   <= cnt_q + CW'(1);
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign out_valid  = valid_q;
   assign out_flt    = flt_q;
   assign out_id     = id_q;
   assign conv_count = cnt_q;

endmodule
